// File: rtl/picorv32_ifb_pkg.sv
// Shared types and constants for the PicoRV32 instruction prefetch buffer.
package picorv32_ifb_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    FILL,
    RESP
  } ifb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/picorv32_ifb_line.sv
// Single buffered line: tag, valid bit, word storage, fill write port and hit compare.
module picorv32_ifb_line
  import picorv32_ifb_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int OB         = 2,
  parameter int TW         = WORD_W - OB - 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              tag_ld,
  input  logic [TW-1:0]     tag_in,
  input  logic              vld_set,
  input  logic              vld_clr,
  input  logic              wr_en,
  input  logic [OB-1:0]     wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [TW-1:0]     cmp_tag,
  input  logic [OB-1:0]     rd_idx,
  output logic [WORD_W-1:0] rd_data,
  output logic [TW-1:0]     tag,
  output logic              hit
);

  logic [TW-1:0]     tag_q, tag_d;
  logic              vld_q, vld_d;
  logic [WORD_W-1:0] data_q [LINE_WORDS];

  // Clear has priority so an invalidate can never be lost to a concurrent set.
  always_comb begin
    tag_d = tag_q;
    vld_d = vld_q;
    if (tag_ld)  tag_d = tag_in;
    if (vld_set) vld_d = 1'b1;
    if (vld_clr) vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_q <= '0;
      vld_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_idx] <= wr_data;
  end

  assign rd_data = data_q[rd_idx];
  assign tag     = tag_q;
  assign hit     = vld_q && (tag_q == cmp_tag);

endmodule

// File: rtl/picorv32_ifetch_buffer.sv
// Single-line instruction prefetch buffer between the PicoRV32 native port and a native-protocol downstream.
module picorv32_ifetch_buffer
  import picorv32_ifb_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter bit CACHE_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              dn_valid,
  output logic              dn_instr,
  output logic [WORD_W-1:0] dn_addr,
  output logic [WORD_W-1:0] dn_wdata,
  output logic [3:0]        dn_wstrb,
  input  logic              dn_ready,
  input  logic [WORD_W-1:0] dn_rdata
);

  localparam int            OB       = clog2(LINE_WORDS);
  localparam int            TW       = WORD_W - OB - 2;
  localparam logic [OB-1:0] LAST_IDX = OB'(LINE_WORDS - 1);

  ifb_state_t        state_q, state_d;
  logic              mem_ready_q, mem_ready_d;
  logic [WORD_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              dn_valid_q, dn_valid_d;
  logic              dn_instr_q, dn_instr_d;
  logic [WORD_W-1:0] dn_addr_q, dn_addr_d;
  logic [WORD_W-1:0] dn_wdata_q, dn_wdata_d;
  logic [3:0]        dn_wstrb_q, dn_wstrb_d;
  logic [OB-1:0]     fill_idx_q, fill_idx_d;
  logic [OB-1:0]     word_sel_q, word_sel_d;
  logic              flush_pend_q, flush_pend_d;
  logic              ign_q, ign_d;

  logic              tag_ld, vld_set, vld_clr, wr_en, line_hit, is_iread;
  logic [TW-1:0]     req_tag, line_tag;
  logic [OB-1:0]     req_idx, rd_idx, fill_next;
  logic [WORD_W-1:0] line_rdata;

  assign req_tag   = mem_addr[WORD_W-1:OB+2];
  assign req_idx   = mem_addr[OB+1:2];
  assign rd_idx    = (state_q == FILL) ? word_sel_q : req_idx;
  assign fill_next = fill_idx_q + OB'(1);
  assign is_iread  = mem_instr && (mem_wstrb == 4'b0000);

  picorv32_ifb_line #(
    .LINE_WORDS(LINE_WORDS),
    .OB        (OB),
    .TW        (TW)
  ) u_line (
    .clk    (clk),
    .resetn (resetn),
    .tag_ld (tag_ld),
    .tag_in (req_tag),
    .vld_set(vld_set),
    .vld_clr(vld_clr),
    .wr_en  (wr_en),
    .wr_idx (fill_idx_q),
    .wr_data(dn_rdata),
    .cmp_tag(req_tag),
    .rd_idx (rd_idx),
    .rd_data(line_rdata),
    .tag    (line_tag),
    .hit    (line_hit)
  );

  always_comb begin
    state_d      = state_q;
    mem_ready_d  = 1'b0;
    mem_rdata_d  = mem_rdata_q;
    dn_valid_d   = dn_valid_q;
    dn_instr_d   = dn_instr_q;
    dn_addr_d    = dn_addr_q;
    dn_wdata_d   = dn_wdata_q;
    dn_wstrb_d   = dn_wstrb_q;
    fill_idx_d   = fill_idx_q;
    word_sel_d   = word_sel_q;
    flush_pend_d = flush_pend_q;
    ign_d        = 1'b0;
    tag_ld       = 1'b0;
    vld_set      = 1'b0;
    vld_clr      = 1'b0;
    wr_en        = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush) vld_clr = 1'b1;
        // The cycle after a response is skipped: the CPU is still dropping mem_valid.
        if (mem_valid && !ign_q) begin
          if (CACHE_EN && is_iread && line_hit && !flush) begin
            mem_rdata_d = line_rdata;
            mem_ready_d = 1'b1;
            state_d     = RESP;
          end else if (CACHE_EN && is_iread) begin
            tag_ld     = 1'b1;
            vld_clr    = 1'b1;
            fill_idx_d = '0;
            word_sel_d = req_idx;
            dn_valid_d = 1'b1;
            dn_instr_d = 1'b1;
            dn_wstrb_d = 4'b0000;
            dn_wdata_d = '0;
            dn_addr_d  = {req_tag, {OB{1'b0}}, 2'b00};
            state_d    = FILL;
          end else begin
            if ((mem_wstrb != 4'b0000) && line_hit) vld_clr = 1'b1;
            dn_valid_d = 1'b1;
            dn_instr_d = mem_instr;
            dn_addr_d  = mem_addr;
            dn_wdata_d = mem_wdata;
            dn_wstrb_d = mem_wstrb;
            state_d    = PASS;
          end
        end
      end

      PASS: begin
        if (flush) vld_clr = 1'b1;
        if (dn_ready) begin
          mem_rdata_d = dn_rdata;
          dn_valid_d  = 1'b0;
          mem_ready_d = mem_valid;
          state_d     = mem_valid ? RESP : IDLE;
        end
      end

      FILL: begin
        if (flush) flush_pend_d = 1'b1;
        if (dn_valid_q) begin
          if (dn_ready) begin
            wr_en      = 1'b1;
            dn_valid_d = 1'b0;
          end
        end else if (fill_idx_q == LAST_IDX) begin
          // Gap cycle after the last word: the whole line is now readable.
          vld_set      = !(flush_pend_q || flush);
          mem_rdata_d  = line_rdata;
          flush_pend_d = 1'b0;
          mem_ready_d  = mem_valid;
          state_d      = mem_valid ? RESP : IDLE;
        end else begin
          fill_idx_d = fill_next;
          dn_valid_d = 1'b1;
          dn_addr_d  = {line_tag, fill_next, 2'b00};
        end
      end

      RESP: begin
        if (flush) vld_clr = 1'b1;
        ign_d   = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      mem_ready_q  <= 1'b0;
      mem_rdata_q  <= '0;
      dn_valid_q   <= 1'b0;
      dn_instr_q   <= 1'b0;
      dn_addr_q    <= '0;
      dn_wdata_q   <= '0;
      dn_wstrb_q   <= 4'b0000;
      fill_idx_q   <= '0;
      word_sel_q   <= '0;
      flush_pend_q <= 1'b0;
      ign_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_ready_q  <= mem_ready_d;
      mem_rdata_q  <= mem_rdata_d;
      dn_valid_q   <= dn_valid_d;
      dn_instr_q   <= dn_instr_d;
      dn_addr_q    <= dn_addr_d;
      dn_wdata_q   <= dn_wdata_d;
      dn_wstrb_q   <= dn_wstrb_d;
      fill_idx_q   <= fill_idx_d;
      word_sel_q   <= word_sel_d;
      flush_pend_q <= flush_pend_d;
      ign_q        <= ign_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign dn_valid  = dn_valid_q;
  assign dn_instr  = dn_instr_q;
  assign dn_addr   = dn_addr_q;
  assign dn_wdata  = dn_wdata_q;
  assign dn_wstrb  = dn_wstrb_q;

endmodule

// File: tb/tb_picorv32_ifetch_buffer.sv
// Randomized self-checking bench: downstream memory stub plus a line-level reference model.
module tb_picorv32_ifetch_buffer;

  localparam int          LW    = 4;
  localparam logic [31:0] LMASK = ~32'(LW * 4 - 1);

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        dn_valid;
  logic        dn_instr;
  logic [31:0] dn_addr;
  logic [31:0] dn_wdata;
  logic [3:0]  dn_wstrb;
  logic        dn_ready;
  logic [31:0] dn_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  picorv32_ifetch_buffer #(.LINE_WORDS(LW), .CACHE_EN(1'b1)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .mem_valid(mem_valid),
    .mem_instr(mem_instr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .dn_valid (dn_valid),
    .dn_instr (dn_instr),
    .dn_addr  (dn_addr),
    .dn_wdata (dn_wdata),
    .dn_wstrb (dn_wstrb),
    .dn_ready (dn_ready),
    .dn_rdata (dn_rdata)
  );

  // ---------------- downstream memory stub ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } dn_txn_t;

  dn_txn_t     dn_log[$];
  logic [31:0] mem_a[logic [31:0]];
  int          dly = 2;  // cycles from dn_valid rising to the dn_ready pulse
  int          vcnt;
  bit          gap_chk;
  bit          holding;
  logic [31:0] hold_addr;
  logic [3:0]  hold_wstrb;
  int          gap_err = 0;
  int          hold_err = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem_a.exists(w)) return mem_a[w];
    return {w[15:0], ~w[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic void log_txn(input logic [31:0] a, input logic [31:0] wd,
                                  input logic [3:0] ws, input logic ins);
    dn_txn_t t;
    logic [31:0] w;
    t.addr = a; t.wdata = wd; t.wstrb = ws; t.instr = ins;
    dn_log.push_back(t);
    w = mem_rd(a);
    for (int b = 0; b < 4; b++) if (ws[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    mem_a[{a[31:2], 2'b00}] = w;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dn_ready <= 1'b0;
      dn_rdata <= '0;
      vcnt     <= 0;
      gap_chk  <= 1'b0;
      holding  <= 1'b0;
    end else begin
      dn_ready <= 1'b0;
      gap_chk  <= dn_ready;
      if (gap_chk && dn_valid) gap_err <= gap_err + 1;
      if (dn_valid && !dn_ready) begin
        if (holding && (dn_addr !== hold_addr || dn_wstrb !== hold_wstrb)) hold_err <= hold_err + 1;
        holding    <= 1'b1;
        hold_addr  <= dn_addr;
        hold_wstrb <= dn_wstrb;
        if (vcnt + 1 >= dly) begin
          dn_ready <= 1'b1;
          dn_rdata <= mem_rd(dn_addr);
          vcnt     <= 0;
          holding  <= 1'b0;
          log_txn(dn_addr, dn_wdata, dn_wstrb, dn_instr);
        end else begin
          vcnt <= vcnt + 1;
        end
      end
    end
  end

  // ---------------- reference model: one line of tag + valid ----------------
  bit          m_vld = 1'b0;
  logic [31:0] m_base = '0;

  task automatic model_predict(input logic [31:0] a, input logic ins, input logic [3:0] ws,
                               input bit fl, output logic [31:0] e_rd,
                               output int e_lat, output int e_ndn);
    bit iread;
    iread = ins && (ws == 4'b0000);
    if (fl) m_vld = 1'b0;
    e_rd = mem_rd(a);
    if (iread && m_vld && ((a & LMASK) == m_base)) begin
      e_lat = 1; e_ndn = 0;
    end else if (iread) begin
      e_lat = LW * (dly + 2) + 1; e_ndn = LW;
      m_vld = 1'b1; m_base = a & LMASK;
    end else begin
      e_lat = dly + 2; e_ndn = 1;
      if ((ws != 4'b0000) && ((a & LMASK) == m_base)) m_vld = 1'b0;
    end
  endtask

  task automatic access(input logic [31:0] a, input logic ins, input logic [3:0] ws,
                        input logic [31:0] wd, input bit fl, output logic [31:0] rd,
                        output int lat, output int ndn, output int q0);
    bit done;
    @(negedge clk);
    q0 = dn_log.size();
    mem_valid = 1'b1; mem_instr = ins; mem_addr = a; mem_wstrb = ws; mem_wdata = wd; flush = fl;
    lat = 0; done = 1'b0; rd = '0;
    while (!done && lat < 500) begin
      @(negedge clk);
      flush = 1'b0;
      lat++;
      if (mem_ready) begin
        done = 1'b1;
        rd = mem_rdata;
      end
    end
    mem_valid = 1'b0; mem_wstrb = '0; flush = 1'b0;
    ndn = dn_log.size() - q0;
    if (!done) begin
      total++; bad++;
      $display("FAIL access_timeout addr=%h: mem_ready never seen within %0d cycles", a, lat);
    end
    $display("txn addr=%h instr=%0b wstrb=%h flush=%0b rdata=%h lat=%0d dn=%0d",
             a, ins, ws, fl, rd, lat, ndn);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL rst_mem_ready got=%b want=0", mem_ready); end
    total++; if (mem_rdata !== 32'h0) begin bad++; $display("FAIL rst_mem_rdata got=%h want=0", mem_rdata); end
    total++; if (dn_valid !== 1'b0) begin bad++; $display("FAIL rst_dn_valid got=%b want=0", dn_valid); end
    total++; if ({dn_instr, dn_wstrb, dn_addr, dn_wdata} !== 69'h0) begin
      bad++; $display("FAIL rst_dn_fields got=%b/%h/%h/%h want=0", dn_instr, dn_wstrb, dn_addr, dn_wdata);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_miss_hit();
    logic [31:0] rd, e_rd;
    int lat, ndn, q0, e_lat, e_ndn;
    dly = 2;
    model_predict(32'h104, 1'b1, 4'h0, 1'b0, e_rd, e_lat, e_ndn);
    access(32'h104, 1'b1, 4'h0, '0, 1'b0, rd, lat, ndn, q0);
    total++; if (ndn !== e_ndn) begin bad++; $display("FAIL miss_dn_count got=%0d want=%0d", ndn, e_ndn); end
    total++; if (rd !== e_rd) begin bad++; $display("FAIL miss_rdata got=%h want=%h", rd, e_rd); end
    total++; if (lat !== e_lat) begin bad++; $display("FAIL miss_latency got=%0d want=%0d", lat, e_lat); end
    for (int i = 0; i < LW; i++) begin
      if (q0 + i < dn_log.size()) begin
        total++;
        if (dn_log[q0+i].addr !== 32'h100 + 32'(4 * i) || dn_log[q0+i].instr !== 1'b1 || dn_log[q0+i].wstrb !== 4'h0) begin
          bad++;
          $display("FAIL miss_fill_word%0d got addr=%h instr=%b wstrb=%h want addr=%h instr=1 wstrb=0",
                   i, dn_log[q0+i].addr, dn_log[q0+i].instr, dn_log[q0+i].wstrb, 32'h100 + 32'(4 * i));
        end
      end
    end
    model_predict(32'h10C, 1'b1, 4'h0, 1'b0, e_rd, e_lat, e_ndn);
    access(32'h10C, 1'b1, 4'h0, '0, 1'b0, rd, lat, ndn, q0);
    total++; if (ndn !== 0) begin bad++; $display("FAIL hit_dn_count got=%0d want=0", ndn); end
    total++; if (lat !== 1) begin bad++; $display("FAIL hit_latency got=%0d want=1", lat); end
    total++; if (rd !== e_rd) begin bad++; $display("FAIL hit_rdata got=%h want=%h", rd, e_rd); end
  endtask

  task automatic test_write_inval();
    logic [31:0] rd, e_rd, wd;
    int lat, ndn, q0, e_lat, e_ndn;
    dly = 1;
    wd = $urandom;
    model_predict(32'h108, 1'b0, 4'h1, 1'b0, e_rd, e_lat, e_ndn);
    access(32'h108, 1'b0, 4'h1, wd, 1'b0, rd, lat, ndn, q0);
    total++; if (ndn !== 1) begin bad++; $display("FAIL wr_dn_count got=%0d want=1", ndn); end
    if (ndn > 0) begin
      total++;
      if (dn_log[q0].addr !== 32'h108 || dn_log[q0].wstrb !== 4'h1 || dn_log[q0].wdata !== wd || dn_log[q0].instr !== 1'b0) begin
        bad++;
        $display("FAIL wr_passthru got addr=%h wstrb=%h wdata=%h instr=%b want addr=108 wstrb=1 wdata=%h instr=0",
                 dn_log[q0].addr, dn_log[q0].wstrb, dn_log[q0].wdata, dn_log[q0].instr, wd);
      end
    end
    total++; if (lat !== e_lat) begin bad++; $display("FAIL wr_latency got=%0d want=%0d", lat, e_lat); end
    model_predict(32'h100, 1'b1, 4'h0, 1'b0, e_rd, e_lat, e_ndn);
    access(32'h100, 1'b1, 4'h0, '0, 1'b0, rd, lat, ndn, q0);
    total++; if (ndn !== LW) begin bad++; $display("FAIL wr_refill_count got=%0d want=%0d", ndn, LW); end
    model_predict(32'h108, 1'b1, 4'h0, 1'b0, e_rd, e_lat, e_ndn);
    access(32'h108, 1'b1, 4'h0, '0, 1'b0, rd, lat, ndn, q0);
    total++; if (rd !== e_rd || ndn !== 0) begin bad++; $display("FAIL wr_new_data got=%h/dn%0d want=%h/dn0", rd, ndn, e_rd); end
  endtask

  task automatic test_data_read();
    logic [31:0] rd, e_rd;
    int lat, ndn, q0, e_lat, e_ndn;
    dly = 3;
    model_predict(32'h104, 1'b0, 4'h0, 1'b0, e_rd, e_lat, e_ndn);
    access(32'h104, 1'b0, 4'h0, '0, 1'b0, rd, lat, ndn, q0);
    total++; if (ndn !== 1) begin bad++; $display("FAIL dread_dn_count got=%0d want=1", ndn); end
    total++; if (rd !== e_rd) begin bad++; $display("FAIL dread_rdata got=%h want=%h", rd, e_rd); end
    total++; if (lat !== e_lat) begin bad++; $display("FAIL dread_latency got=%0d want=%0d", lat, e_lat); end
    if (ndn > 0) begin
      total++;
      if (dn_log[q0].instr !== 1'b0 || dn_log[q0].addr !== 32'h104) begin
        bad++; $display("FAIL dread_fields got instr=%b addr=%h want instr=0 addr=104", dn_log[q0].instr, dn_log[q0].addr);
      end
    end
    model_predict(32'h104, 1'b1, 4'h0, 1'b0, e_rd, e_lat, e_ndn);
    access(32'h104, 1'b1, 4'h0, '0, 1'b0, rd, lat, ndn, q0);
    total++; if (ndn !== 0 || lat !== 1) begin bad++; $display("FAIL dread_line_kept got dn=%0d lat=%0d want dn=0 lat=1", ndn, lat); end
  endtask

  task automatic test_flush_fill();
    logic [31:0] rd, e_rd;
    int lat, ndn, q0, e_lat, e_ndn;
    bit hit_word2;
    dly = 2;
    hit_word2 = 1'b0;
    model_predict(32'h304, 1'b1, 4'h0, 1'b0, e_rd, e_lat, e_ndn);
    fork
      access(32'h304, 1'b1, 4'h0, '0, 1'b0, rd, lat, ndn, q0);
      begin
        for (int i = 0; i < 200 && !hit_word2; i++) begin
          @(negedge clk);
          if (dn_valid && dn_addr == 32'h308) begin
            hit_word2 = 1'b1;
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
          end
        end
      end
    join
    m_vld = 1'b0;
    total++; if (!hit_word2) begin bad++; $display("FAIL flush_word2_seen got=0 want=1"); end
    total++; if (rd !== e_rd) begin bad++; $display("FAIL flush_rdata got=%h want=%h", rd, e_rd); end
    model_predict(32'h304, 1'b1, 4'h0, 1'b0, e_rd, e_lat, e_ndn);
    access(32'h304, 1'b1, 4'h0, '0, 1'b0, rd, lat, ndn, q0);
    total++; if (ndn !== LW) begin bad++; $display("FAIL flush_refetch_miss got dn=%0d want=%0d", ndn, LW); end
    total++; if (rd !== e_rd) begin bad++; $display("FAIL flush_refetch_rdata got=%h want=%h", rd, e_rd); end
  endtask

  task automatic test_reset_midfill();
    logic [31:0] rd, e_rd;
    int lat, ndn, q0, e_lat, e_ndn;
    bit seen;
    dly = 3;
    seen = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1; mem_instr = 1'b1; mem_wstrb = 4'h0; mem_addr = 32'h208;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dn_valid) seen = 1'b1;
    end
    total++; if (!seen) begin bad++; $display("FAIL rstfill_dn_valid_seen got=0 want=1"); end
    #2 resetn = 1'b0;
    #1;
    total++; if (dn_valid !== 1'b0 || mem_ready !== 1'b0) begin
      bad++; $display("FAIL rstfill_async_ctrl got dn_valid=%b mem_ready=%b want 0/0", dn_valid, mem_ready);
    end
    total++; if ({dn_instr, dn_wstrb, dn_addr, dn_wdata, mem_rdata} !== 101'h0) begin
      bad++; $display("FAIL rstfill_async_data got %b/%h/%h/%h/%h want all 0", dn_instr, dn_wstrb, dn_addr, dn_wdata, mem_rdata);
    end
    mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    m_vld = 1'b0;
    repeat (2) @(negedge clk);
    model_predict(32'h208, 1'b1, 4'h0, 1'b0, e_rd, e_lat, e_ndn);
    access(32'h208, 1'b1, 4'h0, '0, 1'b0, rd, lat, ndn, q0);
    total++; if (ndn !== LW || rd !== e_rd) begin
      bad++; $display("FAIL rstfill_refetch got dn=%0d rdata=%h want dn=%0d rdata=%h", ndn, rd, LW, e_rd);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, e_rd, want;
    int lat, ndn, q0, e_lat, e_ndn;
    dly = 1;
    model_predict(32'hFFFF_FFF8, 1'b1, 4'h0, 1'b0, e_rd, e_lat, e_ndn);
    access(32'hFFFF_FFF8, 1'b1, 4'h0, '0, 1'b0, rd, lat, ndn, q0);
    total++; if (ndn !== LW || rd !== e_rd) begin
      bad++; $display("FAIL wrap_fill got dn=%0d rdata=%h want dn=%0d rdata=%h", ndn, rd, LW, e_rd);
    end
    for (int i = 0; i < LW; i++) begin
      want = 32'hFFFF_FFF0 + 32'(4 * i);
      if (q0 + i < dn_log.size()) begin
        total++;
        if (dn_log[q0+i].addr !== want) begin bad++; $display("FAIL wrap_addr%0d got=%h want=%h", i, dn_log[q0+i].addr, want); end
      end
    end
    model_predict(32'hFFFF_FFFC, 1'b1, 4'h0, 1'b0, e_rd, e_lat, e_ndn);
    access(32'hFFFF_FFFC, 1'b1, 4'h0, '0, 1'b0, rd, lat, ndn, q0);
    total++; if (ndn !== 0 || lat !== 1 || rd !== e_rd) begin
      bad++; $display("FAIL wrap_hit got dn=%0d lat=%0d rdata=%h want dn=0 lat=1 rdata=%h", ndn, lat, rd, e_rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, e_rd, a, wd, bases[4];
    logic [3:0]  ws;
    logic        ins;
    bit          fl;
    int lat, ndn, q0, e_lat, e_ndn, kind;
    bases[0] = 32'h100; bases[1] = 32'h300; bases[2] = 32'h340; bases[3] = 32'h1000;
    for (int n = 0; n < 40; n++) begin
      dly  = $urandom_range(1, 4);
      kind = $urandom_range(0, 9);
      a    = bases[$urandom_range(0, 3)] + 32'(4 * $urandom_range(0, LW - 1));
      fl   = ($urandom_range(0, 7) == 0);
      wd   = $urandom;
      ins  = (kind < 6);
      ws   = (kind >= 8) ? 4'($urandom_range(1, 15)) : 4'h0;
      if (ws == 4'h0) a = a | 32'($urandom_range(0, 3));
      model_predict(a, ins, ws, fl, e_rd, e_lat, e_ndn);
      access(a, ins, ws, wd, fl, rd, lat, ndn, q0);
      total++; if (ndn !== e_ndn) begin bad++; $display("FAIL rnd%0d_dn_count got=%0d want=%0d", n, ndn, e_ndn); end
      total++; if (lat !== e_lat) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, lat, e_lat); end
      if (ws == 4'h0) begin
        total++; if (rd !== e_rd) begin bad++; $display("FAIL rnd%0d_rdata got=%h want=%h", n, rd, e_rd); end
      end
    end
  endtask

  task automatic test_protocol();
    total++; if (gap_err !== 0) begin bad++; $display("FAIL dn_gap_after_ready got=%0d violations want=0", gap_err); end
    total++; if (hold_err !== 0) begin bad++; $display("FAIL dn_hold_stable got=%0d violations want=0", hold_err); end
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_write_inval();
    test_data_read();
    test_flush_fill();
    test_reset_midfill();
    test_wrap();
    test_random();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
